// File: rtl/vga_pkg.sv
// Shared VGA definitions for the receiver and the timing generator.
// Covers the lock state encoding, the colour width and the default 1024x768 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    VERIFY,
    LOCKED
  } rxState_e;

  localparam int COLOR_W         = 12;
  localparam int DEF_CW          = 12;
  localparam int DEF_H_ACTIVE    = 1024;
  localparam int DEF_H_BP        = 144;
  localparam int DEF_V_ACTIVE    = 768;
  localparam int DEF_V_BP        = 29;
  localparam int DEF_LOCK_FRAMES = 2;

endpackage

// File: rtl/vga_sync_edge.sv
// Falling/rising edge detector for one active-low sync line; edges are combinational from the sampled level.
// With VGA_RX_INPUT_SYNC_EN defined, the line first passes two flop stages. There is no backpressure.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic syncN,
  output logic fall,
  output logic rise
);

  logic level;
  logic prevLevel;

`ifdef VGA_RX_INPUT_SYNC_EN
  logic [1:0] syncPipe;

  always_ff @(posedge clk) begin
    if (rst) syncPipe <= 2'b11;
    else     syncPipe <= {syncPipe[0], syncN};
  end

  assign level = syncPipe[1];
`else
  assign level = syncN;
`endif

  // Idle-high reset value keeps reset from manufacturing a false edge.
  always_ff @(posedge clk) begin
    if (rst) prevLevel <= 1'b1;
    else     prevLevel <= level;
  end

  assign fall = prevLevel & ~level;
  assign rise = ~prevLevel & level;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sink: measures line and frame timing, locks on it and recovers pixel coordinates.
// Latency is 1 cycle, or 3 with VGA_RX_INPUT_SYNC_EN; it has no backpressure.
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_BP        = DEF_V_BP,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsync_n,
  input  logic               vsync_n,
  input  logic [COLOR_W-1:0] pixel_in,
  output logic [COLOR_W-1:0] pixel_out,
  output logic [CW-1:0]      pix_x,
  output logic [CW-1:0]      pix_y,
  output logic               pix_valid,
  output logic               frame_start,
  output logic               locked,
  output logic [CW-1:0]      h_total,
  output logic [CW-1:0]      v_total,
  output logic               err
);

  localparam logic [CW-1:0] CntMax    = '1;
  localparam logic [CW-1:0] One       = CW'(1);
  localparam logic [CW-1:0] HBeg      = CW'(H_BP);
  localparam logic [CW-1:0] HEnd      = CW'(H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VBeg      = CW'(V_BP);
  localparam logic [CW-1:0] VEnd      = CW'(V_BP + V_ACTIVE);
  localparam logic [CW-1:0] MatchLock = CW'(LOCK_FRAMES + 1);

  logic hFall, hRise, vFall, vRise;
  logic [COLOR_W-1:0] pixSampled;

  vga_sync_edge uHsyncEdge (.clk(clk), .rst(rst), .syncN(hsync_n), .fall(hFall), .rise(hRise));
  vga_sync_edge uVsyncEdge (.clk(clk), .rst(rst), .syncN(vsync_n), .fall(vFall), .rise(vRise));

`ifdef VGA_RX_INPUT_SYNC_EN
  logic [COLOR_W-1:0] pixPipe0, pixPipe1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixPipe0 <= '0;
      pixPipe1 <= '0;
    end else begin
      pixPipe0 <= pixel_in;
      pixPipe1 <= pixPipe0;
    end
  end

  assign pixSampled = pixPipe1;
`else
  assign pixSampled = pixel_in;
`endif

  rxState_e state;
  logic [CW-1:0] hCnt, lCnt, hPos, vLine, matchCnt;
  logic [CW-1:0] lineSample, frameSample, hPosNow, vLineNow;
  logic hSat, lSat, hMis, vMis, lossNow, inActive, pixEn;

  assign hSat        = (hCnt == CntMax);
  assign lSat        = (lCnt == CntMax);
  assign lineSample  = hSat ? CntMax : hCnt + One;
  // A line that starts on the same edge as the frame belongs to the frame being closed.
  assign frameSample = lCnt + CW'(hFall);
  assign hPosNow     = hRise ? '0 : hPos + One;
  assign vLineNow    = vRise ? '0 : (hRise ? vLine + One : vLine);
  assign inActive    = (hPosNow >= HBeg) && (hPosNow < HEnd) &&
                       (vLineNow >= VBeg) && (vLineNow < VEnd);
  assign hMis        = hFall && (lineSample != h_total);
  assign vMis        = vFall && (frameSample != v_total);
  assign lossNow     = (state == LOCKED) && (hSat || lSat || hMis || vMis);
  assign pixEn       = (state == LOCKED) && !lossNow && inActive;

  always_ff @(posedge clk) begin
    if (rst) begin
      hCnt  <= '0;
      lCnt  <= '0;
      hPos  <= '0;
      vLine <= '0;
    end else begin
      hCnt <= hFall ? '0 : (hSat ? hCnt : hCnt + One);
      if (vFall)              lCnt <= '0;
      else if (hFall && !lSat) lCnt <= lCnt + One;
      hPos  <= hPosNow;
      vLine <= vLineNow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pixel_out   <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= pixEn;
      pix_x       <= pixEn ? hPosNow - HBeg : '0;
      pix_y       <= pixEn ? vLineNow - VBeg : '0;
      pixel_out   <= pixEn ? pixSampled : '0;
      frame_start <= pixEn && (hPosNow == HBeg) && (vLineNow == VBeg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      h_total  <= '0;
      v_total  <= '0;
      matchCnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        SEARCH: if (vFall) state <= MEASURE;
        MEASURE: begin
          if (hSat || lSat) state <= SEARCH;
          else begin
            if (hFall) h_total <= lineSample;
            if (vFall) begin
              v_total  <= frameSample;
              matchCnt <= One;
              state    <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (hSat || lSat) state <= SEARCH;
          else if (hMis || vMis) begin
            // Restart measurement from this edge instead of waiting a whole frame.
            if (hFall) h_total <= lineSample;
            state <= MEASURE;
          end else if (vFall) begin
            if (matchCnt + One == MatchLock) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              matchCnt <= matchCnt + One;
            end
          end
        end
        LOCKED: begin
          if (lossNow) begin
            state  <= SEARCH;
            locked <= 1'b0;
            err    <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboarded bench: a tiny-timing generator queues expected pixels, and a negedge monitor compares them.
module tb_vga_sync_receiver;

`ifdef VGA_RX_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst, hsync_n, vsync_n;
  logic [11:0] pixel_in, pixel_out, pix_x, pix_y, h_total, v_total;
  logic pix_valid, frame_start, locked, err;

  int cyc = 0;
  int vectors = 0;
  int failures = 0;
  int errCnt = 0;

  typedef struct {
    int stamp;
    int x;
    int y;
    int pix;
    bit fs;
  } exp_t;
  exp_t expQ[$];

  vga_sync_receiver #(
    .CW(12), .H_ACTIVE(16), .H_BP(3), .V_ACTIVE(8), .V_BP(2), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_n(hsync_n), .vsync_n(vsync_n), .pixel_in(pixel_in),
    .pixel_out(pixel_out), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .h_total(h_total), .v_total(v_total),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pixel_out"}, pixel_out, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_h_total"}, h_total, 0);
    check({tag, "_v_total"}, v_total, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Monitor: pops one expectation per valid pixel; blanking must carry zero pixel data.
  always @(negedge clk) begin
    exp_t e;
    while (expQ.size() > 0 && expQ[0].stamp < cyc) begin
      check("missing_pixel", cyc, expQ[0].stamp);
      void'(expQ.pop_front());
    end
    if (pix_valid) begin
      check("valid_expected", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("pix_latency", cyc, e.stamp);
        check("pix_x", pix_x, e.x);
        check("pix_y", pix_y, e.y);
        check("pixel_out", pixel_out, e.pix);
        check("frame_start", frame_start, int'(e.fs));
      end
    end else begin
      check("blank_pixel_out", pixel_out, 0);
      check("blank_frame_start", frame_start, 0);
    end
    if (err) begin
      errCnt++;
      check("err_locked", locked, 0);
      check("err_pix_valid", pix_valid, 0);
    end
  end

  task automatic drive(input logic h, input logic v, input logic [11:0] px,
                       input bit push, input int x, input int y);
    @(negedge clk);
    hsync_n  = h;
    vsync_n  = v;
    pixel_in = px;
    if (push)
      expQ.push_back('{stamp: cyc + LAT, x: x, y: y, pix: int'(px), fs: (x == 0 && y == 0)});
  endtask

  // Line: sync 4, bp 3, active 16, fp 2 (25). Frame: vsync 2 lines, active lines 3..10.
  task automatic genFrame(input int lines, input bit valid, input int shortLine, input int rstLine);
    bit live, act, rstPend;
    int len, x, y;
    logic [11:0] px;
    live    = valid;
    rstPend = 1'b0;
    for (int k = 0; k < lines; k++) begin
      len = (k == shortLine) ? 24 : 25;
      for (int c = 0; c < len; c++) begin
        x   = c - 7;
        y   = k - 3;
        act = (k >= 3 && k < 11 && c >= 7 && c < 23);
        px  = act ? {y[5:0], x[5:0]} : 12'h5A5;
        drive(c >= 4, k >= 2, px, live && act, x, y);
        if (rstPend) begin
          checkAllZero("midframe_rst");
          rst     = 1'b0;
          rstPend = 1'b0;
        end
        if (k == rstLine && c == 10) begin
          rst     = 1'b1;
          rstPend = 1'b1;
          live    = 1'b0;
          while (expQ.size() > 0 && expQ[$].stamp > cyc) void'(expQ.pop_back());
        end
      end
      if (k == shortLine) live = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1; pixel_in = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int f = 0; f < 3; f++) genFrame(13, 0, -1, -1);
    check("locked_before_frame4", locked, 0);
    genFrame(13, 1, -1, -1);
    genFrame(13, 1, -1, -1);
    check("locked_after_frame4", locked, 1);
    check("h_total", h_total, 25);
    check("v_total", v_total, 13);
    check("err_count_clean", errCnt, 0);
    check("queue_drained_lock", expQ.size(), 0);

    genFrame(13, 1, 5, -1);
    check("err_count_short_line", errCnt, 1);
    check("locked_after_short_line", locked, 0);
    for (int f = 0; f < 3; f++) genFrame(13, 0, -1, -1);
    genFrame(13, 1, -1, -1);
    check("relock_short_line", locked, 1);

    repeat (4200) drive(1'b1, 1'b1, 12'h5A5, 1'b0, 0, 0);
    check("err_count_sync_lost", errCnt, 2);
    check("locked_sync_lost", locked, 0);
    for (int f = 0; f < 3; f++) genFrame(13, 0, -1, -1);
    genFrame(13, 1, -1, -1);
    check("relock_sync_lost", locked, 1);

    genFrame(13, 1, -1, 6);
    check("err_count_after_rst", errCnt, 2);
    for (int f = 0; f < 3; f++) genFrame(13, 0, -1, -1);
    check("locked_rst_before_frame4", locked, 0);
    genFrame(13, 1, -1, -1);
    check("relock_after_rst", locked, 1);
    check("h_total_after_rst", h_total, 25);
    check("v_total_after_rst", v_total, 13);

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    genFrame(13, 0, -1, -1);
    genFrame(13, 0, -1, -1);
    genFrame(14, 0, -1, -1);
    check("locked_vchange_verify", locked, 0);
    for (int f = 0; f < 3; f++) genFrame(14, 0, -1, -1);
    check("locked_vchange_remeasure", locked, 0);
    check("v_total_remeasured", v_total, 14);
    genFrame(14, 1, -1, -1);
    check("locked_v14", locked, 1);
    check("v_total_v14", v_total, 14);
    check("err_count_final", errCnt, 2);

    repeat (5) @(negedge clk);
    check("queue_drained_final", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
